// File: rtl/mod179_arbiter.sv
// mod179_arbiter
//   Shares a single mod-179 reduction unit among NREQ requesters. A
//   round-robin arbiter picks one requester, latches its operand, pulses the
//   unit's start, waits for done (or a watchdog timeout), then returns the
//   result with a one-cycle one-hot ack. Only one transaction is in flight.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   synchronous, active-low reset
//   req       in   [NREQ]     request level per requester
//   req_x     in   [16*NREQ]  packed operands, requester i at [16i+15:16i]
//   ack       out  [NREQ]     one-hot, one-cycle completion pulse
//   res_z     out  [8]        result, valid while ack is nonzero
//   err       out             timeout flag, valid while ack is nonzero
//   busy      out             high whenever the FSM is not idle
//   gnt_id    out  [IDW]      current or last granted requester
//   dp_start  out             one-cycle start pulse to the mod-179 unit
//   dp_x      out  [16]       operand to the unit, stable START..RESP
//   dp_done   in              unit completion pulse (dp_z valid with it)
//   dp_z      in   [8]        unit result
module mod179_arbiter #(
  parameter int  NREQ    = 4,
  parameter int  TIMEOUT = 64,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [16*NREQ-1:0] req_x,
  output logic [NREQ-1:0]   ack,
  output logic [7:0]        res_z,
  output logic              err,
  output logic              busy,
  output logic [IDW-1:0]    gnt_id,
  output logic              dp_start,
  output logic [15:0]       dp_x,
  input  logic              dp_done,
  input  logic [7:0]        dp_z
);

  localparam int WDW = $clog2(TIMEOUT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]      state_r;
  logic [1:0]      state_s;
  logic [IDW-1:0]  ptr_r;
  logic [IDW-1:0]  ptr_s;
  logic [WDW-1:0]  wdog_r;
  logic [WDW-1:0]  wdog_s;
  logic [IDW-1:0]  gnt_s;
  logic [15:0]     x_s;
  logic [NREQ-1:0] ack_s;
  logic [7:0]      z_s;
  logic            err_s;
  logic            busy_s;
  logic            start_s;
  logic [IDW-1:0]  pick_s;
  logic [15:0]     opnd_s [NREQ];

  // First requester with req set, scanning p, p+1, ... wrapping at NREQ.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IDW-1:0]  p);
    logic [IDW-1:0] sel;
    logic           hit;
    logic           take;
    int             idx;
    sel = p;
    hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx  = int'(p) + i;
      idx  = (idx >= NREQ) ? idx - NREQ : idx;
      take = !hit && r[IDW'(idx)];
      sel  = take ? IDW'(idx) : sel;
      hit  = hit | take;
    end
    return sel;
  endfunction

  // Unpack operand slots so the granted one can be selected by index.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      opnd_s[i] = req_x[16*i +: 16];
    end
  end

  // Round-robin choice from the current pointer.
  always_comb begin
    pick_s = rr_pick(req, ptr_r);
  end

  // Next-state and next-output computation; every output is registered below.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    wdog_s  = wdog_r;
    gnt_s   = gnt_id;
    x_s     = dp_x;
    ack_s   = {NREQ{1'b0}};
    z_s     = res_z;
    err_s   = err;
    start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req != {NREQ{1'b0}}) begin
          gnt_s   = pick_s;
          x_s     = opnd_s[pick_s];
          start_s = 1'b1;
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        wdog_s  = {WDW{1'b0}};
        state_s = WAIT;
      end
      WAIT: begin
        // done takes priority, including in the final watchdog cycle
        if (dp_done) begin
          z_s           = dp_z;
          err_s         = 1'b0;
          ack_s[gnt_id] = 1'b1;
          state_s       = RESP;
        end else if (wdog_r == WDW'(TIMEOUT - 1)) begin
          z_s           = 8'd0;
          err_s         = 1'b1;
          ack_s[gnt_id] = 1'b1;
          state_s       = RESP;
        end else begin
          wdog_s = wdog_r + WDW'(1);
        end
      end
      RESP: begin
        // result/err were presented with ack this cycle; clear them on exit
        ptr_s   = (gnt_id == IDW'(NREQ - 1)) ? {IDW{1'b0}} : gnt_id + IDW'(1);
        z_s     = 8'd0;
        err_s   = 1'b0;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      ptr_r    <= {IDW{1'b0}};
      wdog_r   <= {WDW{1'b0}};
      gnt_id   <= {IDW{1'b0}};
      dp_x     <= 16'd0;
      ack      <= {NREQ{1'b0}};
      res_z    <= 8'd0;
      err      <= 1'b0;
      busy     <= 1'b0;
      dp_start <= 1'b0;
    end else begin
      state_r  <= state_s;
      ptr_r    <= ptr_s;
      wdog_r   <= wdog_s;
      gnt_id   <= gnt_s;
      dp_x     <= x_s;
      ack      <= ack_s;
      res_z    <= z_s;
      err      <= err_s;
      busy     <= busy_s;
      dp_start <= start_s;
    end
  end

endmodule
